// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty execution unit.
// Purpose : state and ALU operation encodings, instruction format codes and
//           instruction field bit positions, used by bitty_alu and
//           bitty_exec_unit.
// Ports   : none (package).
package bitty_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_e;

  localparam logic [1:0] FMT_RR  = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;

  // Instruction field bit positions
  localparam int RX_MSB  = 15;
  localparam int RX_LSB  = 13;
  localparam int RY_MSB  = 12;
  localparam int RY_LSB  = 10;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 5;
  localparam int SEL_MSB = 4;
  localparam int SEL_LSB = 2;
  localparam int FMT_MSB = 1;
  localparam int FMT_LSB = 0;

  // Only the reg-reg and immediate formats are defined; 10 and 11 are illegal.
  function automatic logic fmt_is_legal(input logic [1:0] fmt);
    return (fmt == FMT_RR) || (fmt == FMT_IMM);
  endfunction

endpackage

// File: rtl/bitty_alu.sv
// Combinational ALU of the bitty execution unit.
// Purpose : computes result = op(x, y) for the eight bitty ALU operations.
//           All arithmetic is unsigned and wraps modulo 2^DATA_W.
// Ports   : x, y   in  DATA_W  operands
//           sel    in  3       operation select (alu_op_e encoding)
//           result out DATA_W  operation result
module bitty_alu
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] result
);

  // Shifts only look at the low SH_W bits of y.
  logic [SH_W-1:0] sh;
  assign sh = y[SH_W-1:0];

  always_comb begin
    result = '0;
    case (alu_op_e'(sel))
      ALU_ADD: result = x + y;
      ALU_SUB: result = x - y;
      ALU_AND: result = x & y;
      ALU_OR:  result = x | y;
      ALU_XOR: result = x ^ y;
      ALU_SHL: result = x << sh;
      ALU_SHR: result = x >> sh;
      // Compare encodes 0 for equal, 1 for x above y, 2 for x below y.
      ALU_CMP: begin
        if (x == y)     result = '0;
        else if (x > y) result = DATA_W'(1);
        else            result = DATA_W'(2);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bitty_exec_unit.sv
// bitty execution/control unit.
// Purpose : accepts one 16-bit instruction over a valid/ready handshake and
//           runs it through LOAD/CALC/STORE/DONE against an internal 8-entry
//           register file. Illegal formats retire early with err set and
//           leave all architectural state untouched.
// Ports   : clk, reset (async, active-high)
//           instr/instr_valid/instr_ready  instruction handshake
//           done, err                      retire pulse and error qualifier
//           d_out                          last computed result
//           alu_sel                        ALU select of the latched instruction
//           dbg_addr/dbg_data              combinational register read port
module bitty_exec_unit
  import bitty_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SH_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] d_out,
  output logic [2:0]        alu_sel,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // The register fields are 3 bits wide, so the file depth cannot change.
  if (NUM_REGS != 8) begin : g_num_regs_check
    $error("bitty_exec_unit: NUM_REGS must be 8");
  end
  if (DATA_W < 8 || DATA_W > 32) begin : g_data_w_check
    $error("bitty_exec_unit: DATA_W must be in 8..32");
  end

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_CALC  = CALC;
  localparam logic [2:0] S_STORE = STORE;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]        state;
  logic [15:0]       reg_i;
  logic [DATA_W-1:0] reg_s;
  logic [DATA_W-1:0] reg_y;
  logic [DATA_W-1:0] reg_c;
  logic              err_flag;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [1:0]        fmt;
  logic [DATA_W-1:0] operand_y;
  logic [DATA_W-1:0] alu_result;

  // All decoding works from the latched instruction, never the live bus.
  assign rx      = reg_i[RX_MSB:RX_LSB];
  assign ry      = reg_i[RY_MSB:RY_LSB];
  assign fmt     = reg_i[FMT_MSB:FMT_LSB];
  assign alu_sel = reg_i[SEL_MSB:SEL_LSB];

  always_comb begin
    operand_y = regs[ry];
    if (fmt == FMT_IMM) operand_y = DATA_W'(reg_i[IMM_MSB:IMM_LSB]);
  end

  bitty_alu #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_alu (
    .x      (reg_s),
    .y      (reg_y),
    .sel    (alu_sel),
    .result (alu_result)
  );

  // Sequencer: operands are captured in LOAD, so with Rx==Ry the old value
  // is used. The register file is only written in STORE, and an illegal
  // format jumps from LOAD straight to DONE without touching reg_c.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      reg_i    <= '0;
      reg_s    <= '0;
      reg_y    <= '0;
      reg_c    <= '0;
      err_flag <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            reg_i <= instr;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          reg_s <= regs[rx];
          reg_y <= operand_y;
          if (fmt_is_legal(fmt)) begin
            state <= S_CALC;
          end else begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_CALC: begin
          reg_c <= alu_result;
          state <= S_STORE;
        end
        S_STORE: begin
          regs[rx] <= reg_c;
          state    <= S_DONE;
        end
        S_DONE: begin
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = done & err_flag;
  assign d_out       = reg_c;
  assign dbg_data    = regs[dbg_addr];

endmodule

// File: tb/tb_bitty_exec_unit.sv
// Self-checking testbench for bitty_exec_unit.
// Purpose : drives directed and randomized instructions and compares the
//           unit against a behavioural model of the bitty instruction set
//           (register array plus arithmetic reference ALU).
// Ports   : none (top-level bench).
module tb_bitty_exec_unit;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        err;
  logic [15:0] d_out;
  logic [2:0]  alu_sel;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_dout;

  bitty_exec_unit #(
    .DATA_W   (16),
    .NUM_REGS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .d_out       (d_out),
    .alu_sel     (alu_sel),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the operation definitions with plain integer math.
  function automatic logic [15:0] ref_alu(input int unsigned x, input int unsigned y, input int sel);
    int unsigned r;
    int unsigned sh;
    sh = y % 16;
    case (sel)
      0: r = x + y;
      1: r = x + 65536 - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x * (32'd1 << sh);
      6: r = x / (32'd1 << sh);
      default: r = (x == y) ? 0 : ((x > y) ? 1 : 2);
    endcase
    return 16'(r % 65536);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_dout = '0;
  endtask

  task automatic model_exec(input logic [15:0] word);
    int rx;
    int unsigned yv;
    logic [15:0] r;
    rx = int'(word[15:13]);
    if (word[1] == 1'b1) return;
    if (word[0] == 1'b1) yv = int'(word[12:5]);
    else                 yv = int'(m_regs[word[12:10]]);
    r = ref_alu(int'(m_regs[rx]), yv, int'(word[4:2]));
    m_regs[rx] = r;
    m_dout = r;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Issues one instruction and measures in which cycle after the accept edge
  // done rises (0 if it never does within the bound). Also reports err and
  // alu_sel seen with done, and whether done dropped again one cycle later.
  task automatic issue(input logic [15:0] word, output int lat, output logic got_err,
                       output logic [2:0] got_sel, output logic pulse_ok);
    @(negedge clk);
    instr = word;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    model_exec(word);
    lat = 0;
    got_err = 1'b0;
    got_sel = '0;
    pulse_ok = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done) begin
        lat = c;
        got_err = err;
        got_sel = alu_sel;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat != 0) begin
      @(posedge clk);
      #1;
      pulse_ok = !done;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_ready: got %b want 1", instr_ready); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    n_checks++; if (d_out !== 16'h0000) begin n_errors++; $display("[TB] FAIL reset_d_out: got %h want 0000", d_out); end
    n_checks++; if (alu_sel !== 3'd0) begin n_errors++; $display("[TB] FAIL reset_alu_sel: got %0d want 0", alu_sel); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_checks++; if (v !== 16'h0000) begin n_errors++; $display("[TB] FAIL reset_reg R%0d: got %h want 0000", i, v); end
    end
  endtask

  task automatic test_imm_add();
    int lat; logic e; logic [2:0] s; logic p; logic [15:0] v;
    issue(16'h20A1, lat, e, s, p);
    n_checks++; if (lat !== 4) begin n_errors++; $display("[TB] FAIL imm_add1_latency: got %0d want 4", lat); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("[TB] FAIL imm_add1_err: got %b want 0", e); end
    n_checks++; if (p !== 1'b1) begin n_errors++; $display("[TB] FAIL imm_add1_pulse: done not a single-cycle pulse"); end
    issue(16'h5FE1, lat, e, s, p);
    n_checks++; if (lat !== 4) begin n_errors++; $display("[TB] FAIL imm_add2_latency: got %0d want 4", lat); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("[TB] FAIL imm_add2_err: got %b want 0", e); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0005) begin n_errors++; $display("[TB] FAIL imm_add_R1: got %h want 0005", v); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h00FF) begin n_errors++; $display("[TB] FAIL imm_add_R2: got %h want 00FF", v); end
    n_checks++; if (d_out !== 16'h00FF) begin n_errors++; $display("[TB] FAIL imm_add_d_out: got %h want 00FF", d_out); end
  endtask

  task automatic test_rr_sub();
    int lat; logic e; logic [2:0] s; logic p; logic [15:0] v;
    issue(16'h4404, lat, e, s, p);
    n_checks++; if (s !== 3'd1) begin n_errors++; $display("[TB] FAIL sub_alu_sel: got %0d want 1", s); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h00FA) begin n_errors++; $display("[TB] FAIL sub_R2: got %h want 00FA", v); end
    n_checks++; if (d_out !== 16'h00FA) begin n_errors++; $display("[TB] FAIL sub_d_out: got %h want 00FA", d_out); end
    issue(16'h2804, lat, e, s, p);
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'hFF0B) begin n_errors++; $display("[TB] FAIL sub_wrap_R1: got %h want FF0B", v); end
    n_checks++; if (d_out !== 16'hFF0B) begin n_errors++; $display("[TB] FAIL sub_wrap_d_out: got %h want FF0B", d_out); end
  endtask

  task automatic test_shift_cmp();
    int lat; logic e; logic [2:0] s; logic p; logic [15:0] v;
    issue(16'h6021, lat, e, s, p);
    issue(16'h6095, lat, e, s, p);
    read_reg(3'd3, v);
    n_checks++; if (v !== 16'h0010) begin n_errors++; $display("[TB] FAIL shl_R3: got %h want 0010", v); end
    n_checks++; if (s !== 3'd5) begin n_errors++; $display("[TB] FAIL shl_alu_sel: got %0d want 5", s); end
    issue(16'h281C, lat, e, s, p);
    n_checks++; if (d_out !== 16'h0001) begin n_errors++; $display("[TB] FAIL cmp_gt: got %h want 0001", d_out); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0001) begin n_errors++; $display("[TB] FAIL cmp_gt_R1: got %h want 0001", v); end
    issue(16'h6C1C, lat, e, s, p);
    n_checks++; if (d_out !== 16'h0000) begin n_errors++; $display("[TB] FAIL cmp_eq: got %h want 0000", d_out); end
    read_reg(3'd3, v);
    n_checks++; if (v !== 16'h0000) begin n_errors++; $display("[TB] FAIL cmp_eq_R3: got %h want 0000", v); end
  endtask

  task automatic test_illegal();
    int lat; logic e; logic [2:0] s; logic p; logic [15:0] v;
    issue(16'hA661, lat, e, s, p);
    n_checks++; if (d_out !== 16'h0033) begin n_errors++; $display("[TB] FAIL illegal_setup_d_out: got %h want 0033", d_out); end
    issue(16'h0003, lat, e, s, p);
    n_checks++; if (lat !== 2) begin n_errors++; $display("[TB] FAIL illegal_latency: got %0d want 2", lat); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("[TB] FAIL illegal_err: got %b want 1", e); end
    n_checks++; if (d_out !== 16'h0033) begin n_errors++; $display("[TB] FAIL illegal_d_out: got %h want 0033", d_out); end
    issue(16'hFFFE, lat, e, s, p);
    n_checks++; if (lat !== 2) begin n_errors++; $display("[TB] FAIL illegal10_latency: got %0d want 2", lat); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("[TB] FAIL illegal10_err: got %b want 1", e); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_checks++; if (v !== m_regs[i]) begin n_errors++; $display("[TB] FAIL illegal_reg R%0d: got %h want %h", i, v, m_regs[i]); end
    end
    // A following legal instruction must not see a stale error flag.
    issue(16'h0001, lat, e, s, p);
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("[TB] FAIL illegal_flag_clear: got %b want 0", e); end
  endtask

  task automatic test_random();
    int lat; logic e; logic [2:0] s; logic p; logic [15:0] v;
    logic [15:0] w;
    int pick;
    bit legal;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      pick = int'($urandom_range(0, 9));
      if (pick < 5)      w[1:0] = 2'b00;
      else if (pick < 9) w[1:0] = 2'b01;
      else               w[1] = 1'b1;
      legal = (w[1] == 1'b0);
      issue(w, lat, e, s, p);
      n_checks++; if (lat !== (legal ? 4 : 2)) begin n_errors++; $display("[TB] FAIL rand_latency %h: got %0d want %0d", w, lat, legal ? 4 : 2); end
      n_checks++; if (e !== !legal) begin n_errors++; $display("[TB] FAIL rand_err %h: got %b want %b", w, e, !legal); end
      n_checks++; if (s !== w[4:2]) begin n_errors++; $display("[TB] FAIL rand_alu_sel %h: got %0d want %0d", w, s, w[4:2]); end
      n_checks++; if (p !== 1'b1) begin n_errors++; $display("[TB] FAIL rand_pulse %h: done not a single-cycle pulse", w); end
      n_checks++; if (d_out !== m_dout) begin n_errors++; $display("[TB] FAIL rand_d_out %h: got %h want %h", w, d_out, m_dout); end
      read_reg(w[15:13], v);
      n_checks++; if (v !== m_regs[w[15:13]]) begin n_errors++; $display("[TB] FAIL rand_reg %h: got %h want %h", w, v, m_regs[w[15:13]]); end
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_checks++; if (v !== m_regs[i]) begin n_errors++; $display("[TB] FAIL rand_final R%0d: got %h want %h", i, v, m_regs[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    logic [15:0] v;
    @(negedge clk);
    instr = 16'h8021;
    instr_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k != 0) @(negedge clk);
      if (instr_ready) begin
        accepts.push_back(k);
        model_exec(16'h8021);
      end
    end
    instr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (accepts.size() !== 5) begin n_errors++; $display("[TB] FAIL b2b_accepts: got %0d want 5", accepts.size()); end
    for (int i = 1; i < accepts.size(); i++) begin
      n_checks++; if (accepts[i] - accepts[i-1] !== 5) begin n_errors++; $display("[TB] FAIL b2b_gap %0d: got %0d want 5", i, accepts[i] - accepts[i-1]); end
    end
    read_reg(3'd4, v);
    n_checks++; if (v !== m_regs[4]) begin n_errors++; $display("[TB] FAIL b2b_R4: got %h want %h", v, m_regs[4]); end
    n_checks++; if (d_out !== m_dout) begin n_errors++; $display("[TB] FAIL b2b_d_out: got %h want %h", d_out, m_dout); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int seen;
    @(negedge clk);
    instr = 16'h6095;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (instr_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL midreset_ready: got %b want 1", instr_ready); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("[TB] FAIL midreset_err: got %b want 0", err); end
    n_checks++; if (d_out !== 16'h0000) begin n_errors++; $display("[TB] FAIL midreset_d_out: got %h want 0000", d_out); end
    n_checks++; if (alu_sel !== 3'd0) begin n_errors++; $display("[TB] FAIL midreset_alu_sel: got %0d want 0", alu_sel); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_checks++; if (v !== 16'h0000) begin n_errors++; $display("[TB] FAIL midreset_reg R%0d: got %h want 0000", i, v); end
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("[TB] FAIL midreset_no_done: got %0d done cycles want 0", seen); end
    read_reg(3'd3, v);
    n_checks++; if (v !== m_regs[3]) begin n_errors++; $display("[TB] FAIL midreset_R3_after: got %h want %h", v, m_regs[3]); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_imm_add();
    test_rr_sub();
    test_shift_cmp();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
